// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types, widths and error saturation for neuron supervisors
package neuron_pkg;

   localparam int ERR_W = 16;
   localparam int ACT_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      COMPARE = 2'd2,
      LEARN   = 2'd3
   } state_e;

   // Clamp a 34-bit signed difference into the 16-bit signed error range.
   function automatic logic signed [ERR_W-1:0] sat16(input logic signed [ACT_W+1:0] v);
      if (v > 34'sd32767) begin
         return 16'sh7FFF;
      end else if (v < -34'sd32768) begin
         return 16'sh8000;
      end else begin
         return v[ERR_W-1:0];
      end
   endfunction

endpackage

// File: rtl/neuron_error_supervisor_if.sv
// rtl/neuron_error_supervisor_if.sv - target handshake and neuron learning-port bundle
interface neuron_error_supervisor_if;
   import neuron_pkg::*;

   logic                    tgt_valid;
   logic signed [ACT_W-1:0] tgt_data;
   logic                    tgt_ready;
   logic        [ERR_W-1:0] tol;
   logic signed [ACT_W-1:0] neuron_out;
   logic signed [ERR_W-1:0] feedback_error;
   logic                    enable_learning;
   logic                    busy;
   logic                    done;
   logic                    converged;
   logic                    timeout;
   logic             [15:0] epoch_count;

   modport master (
      output tgt_valid, tgt_data, tol, neuron_out,
      input  tgt_ready, feedback_error, enable_learning, busy, done,
             converged, timeout, epoch_count
   );

   modport slave (
      input  tgt_valid, tgt_data, tol, neuron_out,
      output tgt_ready, feedback_error, enable_learning, busy, done,
             converged, timeout, epoch_count
   );

endinterface

// File: rtl/error_saturator.sv
// rtl/error_saturator.sv - 34-bit target/actual difference, shift, saturation and tolerance flag
module error_saturator
   import neuron_pkg::*;
#(
   parameter int ERR_SHIFT = 0
) (
   input  logic signed [ACT_W-1:0] target,
   input  logic signed [ACT_W-1:0] actual,
   input  logic        [ERR_W-1:0] tol,
   output logic signed [ERR_W-1:0] err_sat,
   output logic                    within_tol
);

   logic signed [ACT_W+1:0] diff;
   logic signed [ACT_W+1:0] shifted;
   logic        [ACT_W+1:0] mag;

   always_comb begin
      diff    = {{2{target[ACT_W-1]}}, target} - {{2{actual[ACT_W-1]}}, actual};
      shifted = diff >>> ERR_SHIFT;
      // Tolerance uses the unshifted magnitude so ERR_SHIFT only scales the feedback.
      mag        = diff[ACT_W+1] ? -diff : diff;
      within_tol = (mag <= {{(ACT_W+2-ERR_W){1'b0}}, tol});
      err_sat    = sat16(shifted);
   end

endmodule

// File: rtl/neuron_error_supervisor.sv
// rtl/neuron_error_supervisor.sv - closed-loop learn/settle training controller for one neuron
module neuron_error_supervisor
   import neuron_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int LEARN_CYCLES  = 1,
   parameter int ERR_SHIFT     = 0,
   parameter int MAX_ITER      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   neuron_error_supervisor_if.slave bus
);

   localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0]  LEARN_LOAD  = 8'(LEARN_CYCLES - 1);
   localparam logic [15:0] ITER_LIMIT  = 16'(MAX_ITER);

   state_e                  state_q, state_d;
   logic signed [ACT_W-1:0] tgt_q, tgt_d;
   logic        [ERR_W-1:0] tol_q, tol_d;
   logic             [15:0] iter_q, iter_d;
   logic             [15:0] epoch_q, epoch_d;
   logic              [7:0] cnt_q, cnt_d;
   logic signed [ERR_W-1:0] fb_q, fb_d;
   logic                    learn_q, learn_d;
   logic                    done_q, done_d;
   logic                    conv_q, conv_d;
   logic                    tmo_q, tmo_d;
   logic signed [ERR_W-1:0] err_sat;
   logic                    within_tol;

   error_saturator #(
      .ERR_SHIFT (ERR_SHIFT)
   ) u_sat (
      .target     (tgt_q),
      .actual     (bus.neuron_out),
      .tol        (tol_q),
      .err_sat    (err_sat),
      .within_tol (within_tol)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tgt_q   <= '0;
         tol_q   <= '0;
         iter_q  <= '0;
         epoch_q <= '0;
         cnt_q   <= '0;
         fb_q    <= '0;
         learn_q <= 1'b0;
         done_q  <= 1'b0;
         conv_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         tgt_q   <= tgt_d;
         tol_q   <= tol_d;
         iter_q  <= iter_d;
         epoch_q <= epoch_d;
         cnt_q   <= cnt_d;
         fb_q    <= fb_d;
         learn_q <= learn_d;
         done_q  <= done_d;
         conv_q  <= conv_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.tgt_valid) state_d = SETTLE;
         SETTLE:  if (cnt_q == 8'd0) state_d = COMPARE;
         COMPARE: begin
            if (within_tol || (iter_q == ITER_LIMIT)) state_d = IDLE;
            else                                      state_d = LEARN;
         end
         LEARN:   if (cnt_q == 8'd0) state_d = SETTLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tgt_d   = tgt_q;
      tol_d   = tol_q;
      iter_d  = iter_q;
      epoch_d = epoch_q;
      cnt_d   = cnt_q;
      fb_d    = fb_q;
      learn_d = learn_q;
      done_d  = 1'b0;
      conv_d  = conv_q;
      tmo_d   = tmo_q;
      case (state_q)
         IDLE: begin
            if (bus.tgt_valid) begin
               tgt_d  = bus.tgt_data;
               tol_d  = bus.tol;
               iter_d = '0;
               conv_d = 1'b0;
               tmo_d  = 1'b0;
               cnt_d  = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
         end
         COMPARE: begin
            if (within_tol) begin
               conv_d = 1'b1;
               fb_d   = '0;
               done_d = 1'b1;
            end else if (iter_q == ITER_LIMIT) begin
               tmo_d  = 1'b1;
               conv_d = 1'b0;
               fb_d   = '0;
               done_d = 1'b1;
            end else begin
               fb_d    = err_sat;
               learn_d = 1'b1;
               iter_d  = iter_q + 16'd1;
               epoch_d = (epoch_q == 16'hFFFF) ? epoch_q : epoch_q + 16'd1;
               cnt_d   = LEARN_LOAD;
            end
         end
         LEARN: begin
            // Error is only meaningful while learning is enabled, so both drop together.
            if (cnt_q == 8'd0) begin
               learn_d = 1'b0;
               fb_d    = '0;
               cnt_d   = SETTLE_LOAD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: ;
      endcase
   end

   assign bus.tgt_ready       = (state_q == IDLE);
   assign bus.busy            = (state_q != IDLE);
   assign bus.feedback_error  = fb_q;
   assign bus.enable_learning = learn_q;
   assign bus.done            = done_q;
   assign bus.converged       = conv_q;
   assign bus.timeout         = tmo_q;
   assign bus.epoch_count     = epoch_q;

endmodule

// File: tb/tb_neuron_error_supervisor.sv
// tb/tb_neuron_error_supervisor.sv - self-checking bench for neuron_error_supervisor
module tb_neuron_error_supervisor;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   neuron_error_supervisor_if ifa ();
   neuron_error_supervisor_if ifb ();
   neuron_error_supervisor_if ifc ();

   neuron_error_supervisor dut_a (.clk(clk), .rst(rst), .bus(ifa));
   neuron_error_supervisor #(.MAX_ITER(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
   neuron_error_supervisor #(.ERR_SHIFT(16)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_err(input longint t, input longint n, input int sh);
      longint d;
      d = (t - n) >>> sh;
      if (d > 32767) return 32767;
      if (d < -32768) return -32768;
      return int'(d);
   endfunction

   function automatic bit model_conv(input longint t, input longint n, input int tl);
      longint d;
      d = t - n;
      if (d < 0) d = -d;
      return d <= longint'(tl);
   endfunction

   // One learn pulse on dut_a, then the output is moved to n2 which must converge.
   task automatic learn_then_converge_a(input string tag, input int t, input int n1,
                                        input int n2, input int tl, input int exp_fb);
      ifa.tgt_data = t; ifa.neuron_out = n1; ifa.tol = 16'(tl); ifa.tgt_valid = 1'b1;
      tick();
      ifa.tgt_valid = 1'b0;
      repeat (3) tick();
      chk({tag, "_en"}, 32'(ifa.enable_learning), 32'd1);
      chk({tag, "_fb"}, 32'(ifa.feedback_error), 32'(exp_fb));
      ifa.neuron_out = n2;
      tick();
      chk({tag, "_en_off"}, {31'd0, ifa.enable_learning}, 32'd0);
      chk({tag, "_fb_off"}, 32'(ifa.feedback_error), 32'd0);
      repeat (3) tick();
      chk({tag, "_done"}, {31'd0, ifa.done}, 32'd1);
      chk({tag, "_conv"}, {31'd0, ifa.converged}, 32'd1);
   endtask

   int exp_epoch_a = 0;
   int exp_epoch_c = 0;

   task automatic rand_round(input int t, input int n, input int tl);
      bit conv;
      int ea, ec;
      conv = model_conv(longint'(t), longint'(n), tl);
      ea   = model_err(longint'(t), longint'(n), 0);
      ec   = model_err(longint'(t), longint'(n), 16);
      ifa.tgt_data = t; ifa.neuron_out = n; ifa.tol = 16'(tl); ifa.tgt_valid = 1'b1;
      ifc.tgt_data = t; ifc.neuron_out = n; ifc.tol = 16'(tl); ifc.tgt_valid = 1'b1;
      tick();
      ifa.tgt_valid = 1'b0; ifc.tgt_valid = 1'b0;
      repeat (3) tick();
      if (conv) begin
         chk("rnd_conv_done_a", {31'd0, ifa.done}, 32'd1);
         chk("rnd_conv_en_a", {31'd0, ifa.enable_learning}, 32'd0);
         chk("rnd_conv_done_c", {31'd0, ifc.done}, 32'd1);
      end else begin
         chk("rnd_en_a", {31'd0, ifa.enable_learning}, 32'd1);
         chk("rnd_fb_a", 32'(ifa.feedback_error), 32'(ea));
         chk("rnd_fb_c", 32'(ifc.feedback_error), 32'(ec));
         exp_epoch_a++; exp_epoch_c++;
         ifa.neuron_out = t; ifc.neuron_out = t;
         repeat (4) tick();
         chk("rnd_done_a", {31'd0, ifa.done}, 32'd1);
      end
      chk("rnd_conv_a", {31'd0, ifa.converged}, 32'd1);
      chk("rnd_epoch_a", 32'(ifa.epoch_count), 32'(exp_epoch_a));
      chk("rnd_epoch_c", 32'(ifc.epoch_count), 32'(exp_epoch_c));
   endtask

   initial begin
      int rises, highs, fb_viol, done_cyc;
      int rise_at [4];
      logic prev_en;
      int t, n, tl;
      bit saw_en;

      ifa.tgt_valid = 1'b0; ifa.tgt_data = '0; ifa.tol = '0; ifa.neuron_out = '0;
      ifb.tgt_valid = 1'b0; ifb.tgt_data = '0; ifb.tol = '0; ifb.neuron_out = '0;
      ifc.tgt_valid = 1'b0; ifc.tgt_data = '0; ifc.tol = '0; ifc.neuron_out = '0;

      // Reset asserted between clock edges.
      #13 rst = 1'b1;
      #1;
      chk("rst_ready", {31'd0, ifa.tgt_ready}, 32'd1);
      chk("rst_busy", {31'd0, ifa.busy}, 32'd0);
      chk("rst_en", {31'd0, ifa.enable_learning}, 32'd0);
      chk("rst_fb", 32'(ifa.feedback_error), 32'd0);
      chk("rst_flags", {29'd0, ifa.done, ifa.converged, ifa.timeout}, 32'd0);
      chk("rst_epoch", 32'(ifa.epoch_count), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Target already matched with zero tolerance.
      ifa.tgt_data = 100; ifa.neuron_out = 100; ifa.tol = 16'd0; ifa.tgt_valid = 1'b1;
      tick();
      ifa.tgt_valid = 1'b0;
      chk("match_busy", {31'd0, ifa.busy}, 32'd1);
      saw_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         saw_en = saw_en | ifa.enable_learning;
      end
      chk("match_done", {31'd0, ifa.done}, 32'd1);
      chk("match_conv", {31'd0, ifa.converged}, 32'd1);
      chk("match_no_learn", {31'd0, saw_en}, 32'd0);
      chk("match_epoch", 32'(ifa.epoch_count), 32'd0);
      tick();
      chk("match_done_pulse", {31'd0, ifa.done}, 32'd0);

      learn_then_converge_a("t3", 1000, 0, 998, 2, 1000);
      chk("t3_epoch", 32'(ifa.epoch_count), 32'd1);
      learn_then_converge_a("sat_pos", 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 0, 32'h00007FFF);
      learn_then_converge_a("sat_neg", 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 0, 32'hFFFF8000);
      chk("sat_epoch", 32'(ifa.epoch_count), 32'd3);

      // Shifted error on the ERR_SHIFT=16 instance.
      ifc.tgt_data = 32'h00030000; ifc.neuron_out = 0; ifc.tol = 16'd0; ifc.tgt_valid = 1'b1;
      tick();
      ifc.tgt_valid = 1'b0;
      repeat (3) tick();
      chk("shift_fb", 32'(ifc.feedback_error), 32'd3);
      ifc.neuron_out = 32'h00030000;
      repeat (4) tick();
      chk("shift_done", {30'd0, ifc.done, ifc.converged}, 32'd3);

      // Iteration limit on the MAX_ITER=4 instance.
      ifb.tgt_data = 500; ifb.neuron_out = 0; ifb.tol = 16'd0; ifb.tgt_valid = 1'b1;
      tick();
      ifb.tgt_valid = 1'b0;
      rises = 0; highs = 0; fb_viol = 0; done_cyc = -1; prev_en = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (ifb.enable_learning) highs++;
         if (ifb.enable_learning && !prev_en) begin
            if (rises < 4) rise_at[rises] = c;
            rises++;
         end
         if (!ifb.enable_learning && ifb.feedback_error != 0) fb_viol++;
         prev_en = ifb.enable_learning;
         if (ifb.done) begin
            done_cyc = c;
            break;
         end
      end
      chk("lim_rises", 32'(rises), 32'd4);
      chk("lim_high_cycles", 32'(highs), 32'd4);
      for (int k = 0; k < 4; k++) chk($sformatf("lim_rise%0d", k), 32'(rise_at[k]), 32'(3 + 4 * k));
      chk("lim_done_cycle", 32'(done_cyc), 32'd19);
      chk("lim_fb_idle_zero", 32'(fb_viol), 32'd0);
      chk("lim_timeout", {31'd0, ifb.timeout}, 32'd1);
      chk("lim_conv", {31'd0, ifb.converged}, 32'd0);
      chk("lim_epoch", 32'(ifb.epoch_count), 32'd4);

      // New data offered while busy, then reset during LEARN.
      ifa.tgt_data = 1000; ifa.neuron_out = 0; ifa.tol = 16'd0; ifa.tgt_valid = 1'b1;
      tick();
      ifa.tgt_data = 77777;
      repeat (3) tick();
      chk("busy_ready", {31'd0, ifa.tgt_ready}, 32'd0);
      chk("busy_fb_kept", 32'(ifa.feedback_error), 32'd1000);
      chk("busy_en", {31'd0, ifa.enable_learning}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_learn_en", {31'd0, ifa.enable_learning}, 32'd0);
      chk("rst_learn_fb", 32'(ifa.feedback_error), 32'd0);
      tick();
      chk("rst_learn_no_done", {31'd0, ifa.done}, 32'd0);
      rst = 1'b0;
      chk("rst_learn_ready", {31'd0, ifa.tgt_ready}, 32'd1);
      ifa.tgt_data = 5; ifa.neuron_out = 5;
      tick();
      ifa.tgt_valid = 1'b0;
      repeat (3) tick();
      chk("fresh_done", {30'd0, ifa.done, ifa.converged}, 32'd3);
      chk("fresh_epoch", 32'(ifa.epoch_count), 32'd0);

      // Randomized targets against the reference model.
      for (int r = 0; r < 24; r++) begin
         t = int'($urandom);
         if (r % 2 == 0) begin
            n  = t + int'($urandom_range(0, 20)) - 10;
            tl = int'($urandom_range(0, 12));
         end else begin
            n  = (r % 4 == 1) ? int'($urandom) : t + int'($urandom_range(0, 200000)) - 100000;
            tl = int'($urandom_range(0, 65535));
         end
         rand_round(t, n, tl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/neuron_error_supervisor.md
Name: neuron_error_supervisor

Overview:
Closed-loop training controller for one plastic neuron.
- Accepts a 32-bit signed target through a valid/ready handshake and watches the neuron's 32-bit output.
- Computes a saturated 16-bit signed error and drives the neuron's feedback_error and enable_learning inputs.
- Repeats learn/settle iterations until the output is within tolerance or an iteration limit is reached.
- Sits directly upstream of the neuron's learning ports and downstream of its output.

Parameters:
SETTLE_CYCLES, 2, cycles waited after acceptance or after a learn pulse before sampling neuron_out (range 1..255)
LEARN_CYCLES, 1, cycles enable_learning is held high per iteration (range 1..255)
ERR_SHIFT, 0, arithmetic right shift applied to the raw difference before saturation (range 0..16)
MAX_ITER, 16, learn iterations allowed per target before timeout (range 1..65535)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
tgt_valid  in  1  target offered
tgt_data  in  32  signed target value
tgt_ready  out  1  high only in IDLE
tol  in  16  unsigned tolerance; sampled at acceptance
neuron_out  in  32  signed neuron output
feedback_error  out  16  signed error to neuron
enable_learning  out  1  plasticity enable to neuron
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of a target's training
converged  out  1  result qualifier; valid from the done pulse, held until the next acceptance
timeout  out  1  result qualifier; same validity as converged
epoch_count  out  16  total learn iterations since reset; saturates at 16'hFFFF

Behaviour:
- Reset (async): state IDLE; all counters and the captured target/tol cleared; every output 0 except tgt_ready=1.
- All outputs are registered except tgt_ready and busy, which decode the state register.
- States: IDLE, SETTLE, COMPARE, LEARN.
- IDLE:
  - Acceptance is tgt_valid && tgt_ready at a clock edge.
  - On acceptance: capture tgt_data and tol; clear iter_cnt, converged and timeout; load the settle counter; go to SETTLE.
  - tgt_valid outside IDLE is ignored; no capture occurs.
- SETTLE: stays exactly SETTLE_CYCLES cycles, then goes to COMPARE.
- COMPARE (one cycle):
  - diff = target - neuron_out, computed in 34 bits signed.
  - Arithmetic shift right by ERR_SHIFT, then saturate to [-32768, 32767].
  - Converged test: |diff| (unshifted, 34-bit) <= tol. Result: converged<=1, feedback_error<=0, done pulse, go to IDLE.
  - Else, if iter_cnt == MAX_ITER: timeout<=1, converged<=0, feedback_error<=0, done pulse, go to IDLE.
  - Else: feedback_error<=saturated value, enable_learning<=1, iter_cnt+1, epoch_count+1 (saturating), go to LEARN.
- LEARN:
  - Holds enable_learning=1 and a stable feedback_error for exactly LEARN_CYCLES cycles.
  - At exit: enable_learning<=0, feedback_error<=0, reload the settle counter, go to SETTLE.
- feedback_error is 0 whenever enable_learning is 0.
- Latency: acceptance at edge E0 gives COMPARE in the cycle after E(SETTLE_CYCLES); done/feedback_error are visible after edge E(SETTLE_CYCLES+1).
- Each learn iteration adds LEARN_CYCLES + SETTLE_CYCLES + 1 cycles.
- Zero error with tol=0 counts as converged.
- A target equal to the current output never asserts enable_learning.
- Reset mid-operation:
  - enable_learning and feedback_error drop asynchronously.
  - No done pulse is generated.
  - Any in-flight target is discarded.

Decomposition:
- Shared package neuron_pkg: state enum (IDLE, SETTLE, COMPARE, LEARN), ERR_W=16, ACT_W=32, sat16 saturation function.
- One sub-module, error_saturator: combinational 34-bit diff, shift, and saturation to 16 bits, with a |diff|<=tol flag. It is reused by later multi-neuron supervisors.

Test Plan:
1. Assert rst mid-cycle, then release -> all outputs 0, tgt_ready=1, epoch_count=0.
2. target=100, neuron_out=100, tol=0, accept at E0 -> done=1 and converged=1 after E3; enable_learning never high; epoch_count=0.
3. target=1000, neuron_out=0 -> feedback_error=1000 with enable_learning=1 for 1 cycle. Bench then sets neuron_out=998 with tol=2 -> next COMPARE gives converged=1, epoch_count=1.
4. Saturation, both directions:
   - target=0x7FFFFFFF, neuron_out=0x80000000 -> feedback_error=0x7FFF.
   - Swapped values -> 0x8000.
   - With ERR_SHIFT=16, target=0x00030000, neuron_out=0 -> feedback_error=3.
5. MAX_ITER=4, neuron_out stuck at 0, target=500 -> exactly 4 enable_learning pulses spaced 4 cycles apart; then done=1, timeout=1, converged=0, epoch_count=4.
6. tgt_valid held high with new data while busy -> not captured. Assert rst during LEARN -> enable_learning=0 immediately, no done pulse; after release, tgt_ready=1 and a fresh target is accepted normally.
